io_readback: RTL and testbench

RAM-to-stream read-out engine: on a start pulse it reads a contiguous block of bytes from the processor RAM and presents them one at a time on a valid/ready output stream. It is the reverse path of the file-loader interface that writes incoming bytes into RAM at incrementing addresses. It is used to dump memory contents to the test harness or output device. It shares the 8-bit RAM address/data conventions of the loader.

---
 rtl/io_pkg.sv | 21 ++
 rtl/io_readback_if.sv | 34 +++
 rtl/io_checksum.sv | 37 +++
 rtl/io_readback.sv | 143 ++++++++++++++
 tb/tb_io_readback.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared widths and state encoding for the io readback engine
package io_pkg;

   localparam int IO_ADDR_WIDTH = 8;
   localparam int IO_DATA_WIDTH = 8;

   localparam logic [2:0] IO_RB_IDLE    = 3'd0;
   localparam logic [2:0] IO_RB_ISSUE   = 3'd1;
   localparam logic [2:0] IO_RB_WAIT    = 3'd2;
   localparam logic [2:0] IO_RB_PRESENT = 3'd3;
   localparam logic [2:0] IO_RB_DONE    = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = IO_RB_IDLE,
      ST_ISSUE   = IO_RB_ISSUE,
      ST_WAIT    = IO_RB_WAIT,
      ST_PRESENT = IO_RB_PRESENT,
      ST_DONE    = IO_RB_DONE
   } io_rb_state_e;

endpackage

// File: rtl/io_readback_if.sv
// rtl/io_readback_if.sv - control, RAM read port and output stream of io_readback
interface io_readback_if
   import io_pkg::*;
#(
   parameter int ADDR_WIDTH = IO_ADDR_WIDTH,
   parameter int DATA_WIDTH = IO_DATA_WIDTH
);

   logic                  start;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [ADDR_WIDTH:0]   length;
   logic                  read_enable;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] data_from_ram;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic                  data_ready;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] checksum;

   // engine side
   modport slave (
      input  start, start_addr, length, data_from_ram, data_ready,
      output read_enable, address, data_out, data_valid, busy, done, checksum
   );

   // controller / RAM / consumer side
   modport master (
      output start, start_addr, length, data_from_ram, data_ready,
      input  read_enable, address, data_out, data_valid, busy, done, checksum
   );

endinterface

// File: rtl/io_checksum.sv
// rtl/io_checksum.sv - modular byte-sum accumulator with synchronous clear
module io_checksum #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear_i,
   input  logic                  enable_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] sum_o
);

   logic [DATA_WIDTH-1:0] sum_q;
   logic [DATA_WIDTH-1:0] sum_d;

   // clear wins over accumulate; the sum wraps naturally at DATA_WIDTH bits
   always_comb begin
      sum_d = sum_q;
      if (clear_i) begin
         sum_d = '0;
      end else if (enable_i) begin
         sum_d = sum_q + data_i;
      end
   end

   // accumulator register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/io_readback.sv
// rtl/io_readback.sv - RAM-to-stream read-out engine; IO_READBACK_CHECKSUM_EN adds a byte checksum
module io_readback
   import io_pkg::*;
#(
   parameter int ADDR_WIDTH   = IO_ADDR_WIDTH,
   parameter int DATA_WIDTH   = IO_DATA_WIDTH,
   parameter int READ_LATENCY = 1
) (
   input  logic         clock,
   input  logic         reset,
   io_readback_if.slave bus
);

   // READ_LATENCY is 1 or 2, so a two-bit wait counter always suffices
   localparam logic [1:0]          WAIT_LAST = 2'(READ_LATENCY - 1);
   localparam logic [ADDR_WIDTH:0] REM_LAST  = (ADDR_WIDTH + 1)'(1);

   io_rb_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
   logic [1:0]            wait_cnt_q, wait_cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  read_enable_q, read_enable_d;
   logic                  data_valid_q, data_valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] checksum_w;

   logic handshake;
   logic start_accept;

   // data_valid_q is high exactly while in PRESENT
   assign handshake    = data_valid_q && bus.data_ready;
   assign start_accept = (state_q == ST_IDLE) && bus.start;

   // next-state, counters and the next value of every registered output
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      wait_cnt_d  = wait_cnt_q;
      data_d      = data_q;

      case (state_q)
         ST_IDLE: begin
            if (start_accept) begin
               if (bus.length == '0) begin
                  state_d = ST_DONE;
               end else begin
                  addr_d      = bus.start_addr;
                  remaining_d = bus.length;
                  state_d     = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            wait_cnt_d = '0;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               data_d  = bus.data_from_ram;
               state_d = ST_PRESENT;
            end else begin
               wait_cnt_d = wait_cnt_q + 2'd1;
            end
         end
         ST_PRESENT: begin
            if (handshake) begin
               remaining_d = remaining_q - REM_LAST;
               if (remaining_q == REM_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  addr_d  = addr_q + ADDR_WIDTH'(1);
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // outputs are registered, so they are decoded from the state being entered
      read_enable_d = (state_d == ST_ISSUE);
      data_valid_d  = (state_d == ST_PRESENT);
      busy_d        = (state_d != ST_IDLE);
      done_d        = (state_d == ST_DONE);
   end

   // state, counters and output registers; reset aborts any transfer at once
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         remaining_q   <= '0;
         wait_cnt_q    <= '0;
         data_q        <= '0;
         read_enable_q <= 1'b0;
         data_valid_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         remaining_q   <= remaining_d;
         wait_cnt_q    <= wait_cnt_d;
         data_q        <= data_d;
         read_enable_q <= read_enable_d;
         data_valid_q  <= data_valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

`ifdef IO_READBACK_CHECKSUM_EN
   io_checksum #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_checksum (
      .clock    (clock),
      .reset    (reset),
      .clear_i  (start_accept),
      .enable_i (handshake),
      .data_i   (data_q),
      .sum_o    (checksum_w)
   );
`else
   assign checksum_w = '0;
`endif

   // the address counter doubles as the RAM address, so it holds between reads
   assign bus.read_enable = read_enable_q;
   assign bus.address     = addr_q;
   assign bus.data_out    = data_q;
   assign bus.data_valid  = data_valid_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.checksum    = checksum_w;

endmodule

// File: tb/tb_io_readback.sv
// tb/tb_io_readback.sv - randomized self-checking bench for io_readback
module tb_io_readback;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int RL = 1;

   logic clock;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   start_cyc = 0;

   logic [7:0] mem [256];

   io_readback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   io_readback #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .READ_LATENCY (RL)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // synchronous RAM with one cycle of read latency
   always @(posedge clock) begin
      if (bus.read_enable) bus.data_from_ram <= mem[bus.address];
   end

   // observation of reads, handshakes and done pulses, sampled mid-cycle
   logic [7:0] got_addr[$];
   logic [7:0] got_data[$];
   int         done_cnt = 0;
   int         done_cyc = -1;
   int         first_valid_cyc = -1;
   logic [7:0] done_sum = 8'h00;

   always @(negedge clock) begin
      if (reset === 1'b0) begin
         if (bus.read_enable) got_addr.push_back(bus.address);
         if (bus.data_valid && bus.data_ready) got_data.push_back(bus.data_out);
         if (bus.data_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            done_sum = bus.checksum;
         end
      end
   end

   // reference model: expected read addresses, stream and checksum
   logic [7:0] exp_addr[$];
   logic [7:0] exp_data[$];
   logic [7:0] exp_sum;

   function automatic void build_model(input logic [7:0] sa, input int len);
      int total;
      exp_addr.delete();
      exp_data.delete();
      total = 0;
      for (int i = 0; i < len; i++) begin
         logic [7:0] a;
         a = 8'((int'(sa) + i) % 256);
         exp_addr.push_back(a);
         exp_data.push_back(mem[a]);
         total = total + int'(mem[a]);
      end
      exp_sum = 8'(total % 256);
   endfunction

   function automatic logic [7:0] exp_checksum();
`ifdef IO_READBACK_CHECKSUM_EN
      return exp_sum;
`else
      return 8'h00;
`endif
   endfunction

   task automatic fill_random();
      foreach (mem[i]) mem[i] = 8'($urandom);
   endtask

   task automatic clear_mon();
      got_addr.delete();
      got_data.delete();
      done_cnt = 0;
      done_cyc = -1;
      first_valid_cyc = -1;
   endtask

   task automatic pulse_start(input logic [7:0] sa, input logic [8:0] len);
      bus.start_addr = sa;
      bus.length     = len;
      bus.start      = 1'b1;
      start_cyc      = cyc;
      @(posedge clock); #1;
      bus.start      = 1'b0;
   endtask

   // drives random backpressure (and optionally stray starts) until done or budget
   task automatic run_until_done(input int bp_pct, input bit spam, input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         bus.data_ready = ($urandom_range(0, 99) >= bp_pct);
         if (spam && bus.busy && !bus.done) begin
            bus.start      = 1'($urandom_range(0, 1));
            bus.start_addr = 8'($urandom);
            bus.length     = 9'($urandom_range(0, 256));
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clock); #1;
         n++;
      end
      bus.start      = 1'b0;
      bus.data_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0;
      bus.start_addr = '0;
      bus.length = '0;
      bus.data_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_tests++;
      if ({bus.read_enable, bus.address, bus.data_out, bus.data_valid, bus.busy, bus.done, bus.checksum} !== 28'h0) begin
         n_fail++;
         $display("FAIL reset_values got re=%b addr=%h dout=%h dv=%b busy=%b done=%b sum=%h want all zero",
                  bus.read_enable, bus.address, bus.data_out, bus.data_valid, bus.busy, bus.done, bus.checksum);
      end
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      n_tests++;
      if (bus.busy !== 1'b0 || bus.read_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle got busy=%b re=%b want 0 0", bus.busy, bus.read_enable);
      end
   endtask

   task automatic test_basic();
      foreach (mem[i]) mem[i] = 8'(i) ^ 8'hA5;
      clear_mon();
      bus.data_ready = 1'b1;
      pulse_start(8'h10, 9'd4);
      run_until_done(0, 1'b0, 200);
      build_model(8'h10, 4);
      n_tests++;
      if (got_addr.size() != 4 || got_data.size() != 4) begin
         n_fail++;
         $display("FAIL basic_count got reads=%0d bytes=%0d want 4 4", got_addr.size(), got_data.size());
      end
      foreach (exp_data[i]) begin
         n_tests++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            n_fail++;
            $display("FAIL basic_byte[%0d] got addr=%h data=%h want addr=%h data=%h",
                     i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
         end
      end
      n_tests++;
      if (first_valid_cyc != start_cyc + 2 + RL) begin
         n_fail++;
         $display("FAIL basic_first_valid got cycle %0d want %0d", first_valid_cyc, start_cyc + 2 + RL);
      end
      n_tests++;
      if (done_cnt != 1 || done_cyc != start_cyc + 2 + RL + 3 * (RL + 2) + 1) begin
         n_fail++;
         $display("FAIL basic_done got count=%0d cycle=%0d want 1 %0d",
                  done_cnt, done_cyc, start_cyc + 2 + RL + 3 * (RL + 2) + 1);
      end
      n_tests++;
      if (done_sum !== exp_checksum() || bus.checksum !== exp_checksum()) begin
         n_fail++;
         $display("FAIL basic_checksum got done=%h later=%h want %h", done_sum, bus.checksum, exp_checksum());
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] sa;
      logic [7:0] hold_data;
      logic [7:0] hold_addr;
      int n;
      fill_random();
      sa = 8'($urandom);
      clear_mon();
      bus.data_ready = 1'b0;
      pulse_start(sa, 9'd3);
      n = 0;
      while (bus.data_valid !== 1'b1 && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      hold_data = bus.data_out;
      hold_addr = bus.address;
      n_tests++;
      if (bus.data_valid !== 1'b1 || hold_data !== mem[sa]) begin
         n_fail++;
         $display("FAIL bp_first_byte got valid=%b data=%h want 1 %h", bus.data_valid, hold_data, mem[sa]);
      end
      repeat (5) begin
         @(posedge clock); #1;
         n_tests++;
         if (bus.data_valid !== 1'b1 || bus.data_out !== hold_data || bus.read_enable !== 1'b0 || bus.address !== hold_addr) begin
            n_fail++;
            $display("FAIL bp_hold got dv=%b dout=%h re=%b addr=%h want 1 %h 0 %h",
                     bus.data_valid, bus.data_out, bus.read_enable, bus.address, hold_data, hold_addr);
         end
      end
      run_until_done(0, 1'b0, 200);
      build_model(sa, 3);
      n_tests++;
      if (got_addr.size() != 3 || got_data.size() != 3 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL bp_count got reads=%0d bytes=%0d done=%0d want 3 3 1", got_addr.size(), got_data.size(), done_cnt);
      end
      foreach (exp_data[i]) begin
         n_tests++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            n_fail++;
            $display("FAIL bp_byte[%0d] got addr=%h data=%h want addr=%h data=%h",
                     i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_wrap();
      fill_random();
      clear_mon();
      pulse_start(8'hFE, 9'd4);
      run_until_done(30, 1'b0, 400);
      build_model(8'hFE, 4);
      n_tests++;
      if (got_addr.size() != 4 || got_data.size() != 4 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL wrap_count got reads=%0d bytes=%0d done=%0d want 4 4 1", got_addr.size(), got_data.size(), done_cnt);
      end
      foreach (exp_data[i]) begin
         n_tests++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            n_fail++;
            $display("FAIL wrap_byte[%0d] got addr=%h data=%h want addr=%h data=%h",
                     i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
         end
      end
      n_tests++;
      if (done_sum !== exp_checksum()) begin
         n_fail++;
         $display("FAIL wrap_checksum got %h want %h", done_sum, exp_checksum());
      end
   endtask

   task automatic test_length_zero();
      clear_mon();
      pulse_start(8'($urandom), 9'd0);
      repeat (4) @(posedge clock);
      #1;
      n_tests++;
      if (got_addr.size() != 0 || got_data.size() != 0) begin
         n_fail++;
         $display("FAIL len0_reads got reads=%0d bytes=%0d want 0 0", got_addr.size(), got_data.size());
      end
      n_tests++;
      if (done_cnt != 1 || done_cyc != start_cyc + 1) begin
         n_fail++;
         $display("FAIL len0_done got count=%0d cycle=%0d want 1 %0d", done_cnt, done_cyc, start_cyc + 1);
      end
      n_tests++;
      if (done_sum !== 8'h00) begin
         n_fail++;
         $display("FAIL len0_checksum got %h want 00", done_sum);
      end
   endtask

   task automatic test_length_256();
      logic [7:0] sa;
      fill_random();
      sa = 8'($urandom);
      clear_mon();
      pulse_start(sa, 9'd256);
      run_until_done(25, 1'b0, 4000);
      build_model(sa, 256);
      n_tests++;
      if (got_data.size() != 256 || got_addr.size() != 256 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL len256_count got reads=%0d bytes=%0d done=%0d want 256 256 1", got_addr.size(), got_data.size(), done_cnt);
      end
      foreach (exp_data[i]) begin
         n_tests++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            n_fail++;
            $display("FAIL len256_byte[%0d] got addr=%h data=%h want addr=%h data=%h",
                     i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
         end
      end
      n_tests++;
      if (done_sum !== exp_checksum()) begin
         n_fail++;
         $display("FAIL len256_checksum got %h want %h", done_sum, exp_checksum());
      end
   endtask

   task automatic test_reset_mid_transfer();
      logic [7:0] sa;
      int n;
      fill_random();
      clear_mon();
      bus.data_ready = 1'b1;
      pulse_start(8'($urandom), 9'd6);
      n = 0;
      while (got_data.size() < 2 && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      reset = 1'b1;
      #1;
      n_tests++;
      if ({bus.read_enable, bus.address, bus.data_out, bus.data_valid, bus.busy, bus.done, bus.checksum} !== 28'h0) begin
         n_fail++;
         $display("FAIL midreset_values got re=%b addr=%h dout=%h dv=%b busy=%b done=%b sum=%h want all zero",
                  bus.read_enable, bus.address, bus.data_out, bus.data_valid, bus.busy, bus.done, bus.checksum);
      end
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_tests++;
      if (done_cnt != 0 || got_data.size() != 2 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_abort got done=%0d bytes=%0d busy=%b want 0 2 0", done_cnt, got_data.size(), bus.busy);
      end
      sa = 8'($urandom);
      clear_mon();
      pulse_start(sa, 9'd5);
      run_until_done(20, 1'b0, 400);
      build_model(sa, 5);
      n_tests++;
      if (got_data.size() != 5 || done_cnt != 1 || done_sum !== exp_checksum()) begin
         n_fail++;
         $display("FAIL midreset_restart got bytes=%0d done=%0d sum=%h want 5 1 %h",
                  got_data.size(), done_cnt, done_sum, exp_checksum());
      end
      foreach (exp_data[i]) begin
         n_tests++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            n_fail++;
            $display("FAIL midreset_byte[%0d] got addr=%h data=%h want addr=%h data=%h",
                     i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      logic [7:0] sa;
      fill_random();
      sa = 8'($urandom);
      clear_mon();
      pulse_start(sa, 9'd5);
      run_until_done(30, 1'b1, 400);
      build_model(sa, 5);
      n_tests++;
      if (got_addr.size() != 5 || got_data.size() != 5 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL busystart_count got reads=%0d bytes=%0d done=%0d want 5 5 1", got_addr.size(), got_data.size(), done_cnt);
      end
      foreach (exp_data[i]) begin
         n_tests++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            n_fail++;
            $display("FAIL busystart_byte[%0d] got addr=%h data=%h want addr=%h data=%h",
                     i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++) begin
         logic [7:0] sa;
         int len;
         fill_random();
         sa  = 8'($urandom);
         len = $urandom_range(1, 12);
         clear_mon();
         pulse_start(sa, 9'(len));
         run_until_done($urandom_range(0, 50), 1'b0, 600);
         build_model(sa, len);
         n_tests++;
         if (got_data.size() != len || got_addr.size() != len || done_cnt != 1 || done_sum !== exp_checksum()) begin
            n_fail++;
            $display("FAIL b2b[%0d]_summary got reads=%0d bytes=%0d done=%0d sum=%h want %0d %0d 1 %h",
                     k, got_addr.size(), got_data.size(), done_cnt, done_sum, len, len, exp_checksum());
         end
         foreach (exp_data[i]) begin
            n_tests++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
               n_fail++;
               $display("FAIL b2b[%0d]_byte[%0d] got addr=%h data=%h want addr=%h data=%h",
                        k, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_length_zero();
      test_length_256();
      test_reset_mid_transfer();
      test_start_while_busy();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no completion within time limit want finish");
      $fatal(1, "watchdog");
   end

endmodule
